// File: rtl/gigatron_gamepad_pkg.sv
// Shared constants for the Gigatron gamepad block: sync bit positions, button indices, idle byte.
package gigatron_gamepad_pkg;

  localparam int OUT_VSYNC_BIT = 7;
  localparam int OUT_HSYNC_BIT = 6;

  // Bit position of each pad button in both i_buttons and o_in.
  typedef enum int {
    BTN_RIGHT  = 0,
    BTN_LEFT   = 1,
    BTN_DOWN   = 2,
    BTN_UP     = 3,
    BTN_START  = 4,
    BTN_SELECT = 5,
    BTN_B      = 6,
    BTN_A      = 7
  } btn_e;

  localparam logic [7:0] IN_IDLE  = 8'hFF;
  localparam logic [3:0] CNT_LAST = 4'd7;
  localparam logic [3:0] CNT_DONE = 4'd8;

endpackage

// File: rtl/gigatron_gamepad_filter.sv
// One button input: 2-flop synchronizer, plus a stability debounce when
// GIGATRON_GAMEPAD_DEBOUNCE_EN is defined.
module gigatron_gamepad_filter #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  logic meta;
  logic sync;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

`ifdef GIGATRON_GAMEPAD_DEBOUNCE_EN
  logic [DEBOUNCE_BITS-1:0] count;
  logic                     stable;

  // The all-ones count marks the 2^DEBOUNCE_BITS-th consecutive disagreeing clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      stable <= 1'b1;
    end else if (sync == stable) begin
      count <= '0;
    end else if (&count) begin
      stable <= sync;
      count  <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign filt = stable;
`else
  localparam int unused_debounce_bits = DEBOUNCE_BITS;
  assign filt = sync;
`endif

endmodule

// File: rtl/gigatron_gamepad.sv
// NES-style pad plus input shift register feeding the Gigatron CPU input port.
// Optional debounce: define GIGATRON_GAMEPAD_DEBOUNCE_EN.
module gigatron_gamepad
  import gigatron_gamepad_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_out,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_in,
  output logic       o_strobe
);

  logic [7:0] btn_f;
  logic [7:0] pad_sr;
  logic [7:0] shifter;
  logic [3:0] cnt;
  logic       prev_vs;
  logic       prev_hs;
  logic       vs_rise;
  logic       hs_rise;

  for (genvar i = 0; i < 8; i++) begin : g_btn
    gigatron_gamepad_filter #(
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_filter (
      .clk  (i_clock),
      .reset(i_reset),
      .raw  (i_buttons[i]),
      .filt (btn_f[i])
    );
  end

  // i_out shares our clock, so edges come straight from the previous-sample registers.
  assign vs_rise = i_out[OUT_VSYNC_BIT] & ~prev_vs;
  assign hs_rise = i_out[OUT_HSYNC_BIT] & ~prev_hs;

  // NOTE: every register here uses <= so all reads see pre-edge values, e.g. the 8th shift's o_in.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prev_vs  <= 1'b1;
      prev_hs  <= 1'b1;
      pad_sr   <= IN_IDLE;
      shifter  <= IN_IDLE;
      cnt      <= '0;
      o_in     <= IN_IDLE;
      o_strobe <= 1'b0;
    end else begin
      prev_vs  <= i_out[OUT_VSYNC_BIT];
      prev_hs  <= i_out[OUT_HSYNC_BIT];
      o_strobe <= 1'b0;
      if (vs_rise) begin
        // A partial frame is simply abandoned; the next 8 shifts overwrite shifter fully.
        pad_sr <= btn_f;
        cnt    <= '0;
      end else if (hs_rise && cnt < CNT_DONE) begin
        shifter <= {shifter[6:0], pad_sr[7]};
        pad_sr  <= {pad_sr[6:0], 1'b1};
        cnt     <= cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          o_in     <= {shifter[6:0], pad_sr[7]};
          o_strobe <= 1'b1;
        end
      end
    end
  end

endmodule
